clock_meter: RTL and testbench
==============================

# clock_meter

Synthesizable measurement block for a clock-like input: it is the receiving end of the lab clock generators. It samples an asynchronous square wave `sig_in` on the system clock and reports its high time, low time and period in `clk` cycles, one result per input period. It also flags a stalled input. It sits beside any generated clock or test signal whose frequency and duty cycle must be checked in hardware.

## Interface
- `CNT_W`, 16: width of the high and low counters.
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in`; legal values are 2 or more.
- `TIMEOUT`, 65535: maximum cycles allowed in any one phase before the stall flag is set. Must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W−1.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `enable` in 1: level; measurement runs while it is high.
- `sig_in` in 1: measured signal, asynchronous to `clk`.
- `high_cnt` out CNT_W: `clk` cycles `sig_in` was high in the last complete period.
- `low_cnt` out CNT_W: `clk` cycles `sig_in` was low in the last complete period.
- `period_cnt` out CNT_W+1: `high_cnt + low_cnt`.
- `valid` out 1: one-cycle pulse when new counts are loaded.
- `busy` out 1: high in every state except IDLE.
- `stuck` out 1: sticky flag for a stalled input.

## Operation
- **Input conditioning.** `sig_in` passes through SYNC_STAGES flops and then one more history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Only the synchronized value is used anywhere in the block.
- **State machine:** IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
  - IDLE: when `enable`=1, go to WAIT_RISE. A partial first period is never measured.
  - WAIT_RISE: on rise, set cnt=1 and go to MEAS_HIGH.
  - MEAS_HIGH: cnt increments each cycle. On fall, latch hi_tmp=cnt, set cnt=1, go to MEAS_LOW.
  - MEAS_LOW: cnt increments each cycle. On rise, do all of the following in one edge:
    - load high_cnt=hi_tmp, low_cnt=cnt, period_cnt=hi_tmp+cnt (zero-extended to CNT_W+1);
    - pulse `valid`;
    - clear `stuck`;
    - set cnt=1 and go back to MEAS_HIGH, so measurement is continuous and back-to-back.
- **Timeout.** In WAIT_RISE, MEAS_HIGH or MEAS_LOW, if the phase cycle count reaches TIMEOUT with no qualifying edge:
  - set `stuck`=1, go to WAIT_RISE, reset cnt;
  - the result registers keep their previous values.
  - WAIT_RISE uses the same counter for this check.
- **Counter range.** cnt never exceeds TIMEOUT, so it cannot wrap.
- **Enable low.** On any edge where `enable`=0, go to IDLE and clear cnt and hi_tmp.
  - Result registers and `stuck` hold their values.
  - No `valid` pulse is produced.
- **Simultaneous events:**
  - `rst` beats everything.
  - `enable`=0 beats a pending edge or timeout.
  - A qualifying edge beats a timeout in the same cycle: the edge is taken and `stuck` is not set.
- **Reset:** every output and the state become 0/IDLE, and all sync and history flops become 0. This holds when reset is asserted mid-measurement as well.

## Timing
- All outputs are registered.
- `valid` rises on the SYNC_STAGES-th `clk` edge after the edge that first samples the closing rising edge of `sig_in` high. It lasts exactly one cycle.
- Counts are in `clk` cycles between synchronized edges. For an input synchronous to `clk` that is high for H cycles and low for L cycles, high_cnt=H and low_cnt=L exactly.
- For an asynchronous input, each count is accurate to ±1 cycle.
- Minimum measurable phase is 1 cycle, so the minimum period is 2 cycles.
- The first `valid` after enable arrives after at most 2 full input periods plus sync latency.
- Result registers change only on the same edge that `valid` is asserted.

## Structure
- Package `clock_meter_pkg` holds:
  - the state enum (IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW);
  - default constants for CNT_W, SYNC_STAGES and TIMEOUT.
- Sub-module `sync_edge_det` (parameter STAGES): the synchronizer chain, history flop, and the `rise`/`fall` outputs.
- The top level holds the FSM, counter, hi_tmp, result registers and flags.

## Test plan
- **Reset.** Pulse `rst` with `enable`=1 and `sig_in` toggling → all outputs 0 and state IDLE on the next edge; no `valid` for SYNC_STAGES+2 cycles after release.
- **50 % duty.** 100 MHz `clk`, `sig_in` = 10 MHz at 50 %, synchronous → from the second `valid` onward high_cnt=5, low_cnt=5, period_cnt=10, one `valid` every 10 cycles.
- **30 % duty.** 2 MHz at 30 %, then switch to 70 % → high/low = 15/35, then 35/15 on the first full new period; period_cnt=50 throughout.
- **Stall.** TIMEOUT=100, hold `sig_in` low after a valid measurement → `stuck`=1 exactly 100 cycles into MEAS_LOW with counts unchanged. Resume at 50 % → `stuck` clears with the next `valid`.
- **Enable drop and async input.** Drop `enable` mid-MEAS_HIGH for 3 cycles, then raise it again → no `valid` and counts held; the next result arrives only after a full fresh period. Repeat with asynchronous `sig_in` at 7.3 MHz → counts within ±1 of 6.85/13.7.
- **Edge beats timeout.** Rise occurs on the same cycle cnt reaches TIMEOUT → edge taken, `valid` asserted, `stuck` stays 0.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// -----------------------------------------------------------------------------
// clock_meter_pkg
// Shared definitions for the clock_meter block:
//   - state_t     : measurement FSM states (also exported on the debug port)
//   - DEF_*       : default values for the top-level parameters
// -----------------------------------------------------------------------------
package clock_meter_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 65535;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/clock_meter_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the i_clk domain through STAGES flops,
// keeps one history flop behind the synchronized value and flags its edges.
//
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst    : synchronous active-high reset, clears every flop
//   i_async  : asynchronous input level
//   o_rise   : synchronized value went 0 -> 1 (sync & ~hist)
//   o_fall   : synchronized value went 1 -> 0 (~sync & hist)
// -----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_hist;
    logic              w_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
            r_hist  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_hist  <= r_chain[STAGES-1];
        end
    end

    assign w_sync = r_chain[STAGES-1];
    assign o_rise = w_sync & ~r_hist;
    assign o_fall = ~w_sync & r_hist;

endmodule

// File: rtl/clock_meter.sv
// -----------------------------------------------------------------------------
// clock_meter
// Measures high time, low time and period (in i_clk cycles) of an
// asynchronous square wave, one result per input period, and flags an input
// that stops toggling.
//
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_enable     : level, measurement runs while high
//   i_sig_in     : measured signal, asynchronous to i_clk
//   o_high_cnt   : high cycles of the last complete period
//   o_low_cnt    : low cycles of the last complete period
//   o_period_cnt : o_high_cnt + o_low_cnt
//   o_valid      : one-cycle pulse on the edge the result registers load
//   o_busy       : FSM is in any state other than IDLE
//   o_stuck      : sticky stall flag, cleared by the next o_valid
//   o_state      : debug view of the FSM state
//
// Output protocol: o_valid is a qualifier pulse with no back-pressure. The
// three result registers change only on the edge that raises o_valid and are
// stable at all other times, so a consumer may sample them whenever o_valid
// is high, or at any later cycle.
// -----------------------------------------------------------------------------
module clock_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_sig_in,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic [CNT_W:0]   o_period_cnt,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_stuck,
    output state_t           o_state
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    // edge detection on the synchronized input
    logic w_rise;
    logic w_fall;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sig_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // state and working registers
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_tmp;

    // result registers and flags
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_low_cnt;
    logic [CNT_W:0]   r_period_cnt;
    logic             r_valid;
    logic             r_busy;
    logic             r_stuck;

    // next-state signals
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_hi_tmp_nxt;
    logic             w_load;
    logic             w_timeout;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LP_TIMEOUT);

    // Next-state logic. Priority inside every measuring state is
    // qualifying edge first, then timeout, then plain count; i_enable low
    // overrides all of it. r_cnt is capped at TIMEOUT by the timeout branch,
    // so the increment never wraps.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_tmp_nxt = r_hi_tmp;
        w_load       = 1'b0;
        w_timeout    = 1'b0;

        if (!i_enable) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_hi_tmp_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // never measure the partial period in flight at enable
                    w_state_nxt = ST_WAIT_RISE;
                    w_cnt_nxt   = '0;
                end

                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEAS_HIGH;
                        w_cnt_nxt   = LP_ONE;
                    end else if (w_at_limit) begin
                        w_timeout = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end

                ST_MEAS_HIGH: begin
                    if (w_fall) begin
                        w_state_nxt  = ST_MEAS_LOW;
                        w_hi_tmp_nxt = r_cnt;
                        w_cnt_nxt    = LP_ONE;
                    end else if (w_at_limit) begin
                        w_state_nxt = ST_WAIT_RISE;
                        w_timeout   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end

                ST_MEAS_LOW: begin
                    if (w_rise) begin
                        // closing rise is also the opening rise of the next
                        // period, so measurement continues back-to-back
                        w_state_nxt = ST_MEAS_HIGH;
                        w_load      = 1'b1;
                        w_cnt_nxt   = LP_ONE;
                    end else if (w_at_limit) begin
                        w_state_nxt = ST_WAIT_RISE;
                        w_timeout   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hi_tmp     <= '0;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
            r_period_cnt <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi_tmp <= w_hi_tmp_nxt;
            r_valid  <= w_load;
            // registered copy of the decode so o_busy tracks o_state exactly
            r_busy   <= (w_state_nxt != ST_IDLE);

            if (w_load) begin
                r_high_cnt   <= r_hi_tmp;
                r_low_cnt    <= r_cnt;
                r_period_cnt <= {1'b0, r_hi_tmp} + {1'b0, r_cnt};
            end

            if (w_load) begin
                r_stuck <= 1'b0;
            end else if (w_timeout) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign o_high_cnt   = r_high_cnt;
    assign o_low_cnt    = r_low_cnt;
    assign o_period_cnt = r_period_cnt;
    assign o_valid      = r_valid;
    assign o_busy       = r_busy;
    assign o_stuck      = r_stuck;
    assign o_state      = r_state;

endmodule

// File: tb/tb_clock_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_meter
// Self-checking bench for clock_meter (CNT_W=16, SYNC_STAGES=2, TIMEOUT=100).
// i_clk has a period of 100 time units. A synchronous driver pushes the
// expected {high, low} of a period when the rise closing that period is
// driven; a monitor pops and compares on every o_valid.
// -----------------------------------------------------------------------------
module tb_clock_meter;
    import clock_meter_pkg::*;

    localparam int CNT_W   = 16;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 100;

    // ------------------------------------------------------------------
    // clock / reset
    // ------------------------------------------------------------------
    logic             i_clk;
    logic             i_rst;
    logic             i_enable;
    logic             i_sig_in;
    logic [CNT_W-1:0] o_high_cnt;
    logic [CNT_W-1:0] o_low_cnt;
    logic [CNT_W:0]   o_period_cnt;
    logic             o_valid;
    logic             o_busy;
    logic             o_stuck;
    state_t           o_state;

    initial begin
        i_clk = 1'b0;
        forever #50 i_clk = ~i_clk;
    end

    clock_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_sig_in     (i_sig_in),
        .o_high_cnt   (o_high_cnt),
        .o_low_cnt    (o_low_cnt),
        .o_period_cnt (o_period_cnt),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_stuck      (o_stuck),
        .o_state      (o_state)
    );

    // ------------------------------------------------------------------
    // scoreboard state
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        async_mode = 1'b0;
    int          async_n = 0;
    logic        pend_ok = 1'b0;
    int          pend_h = 0;
    int          pend_l = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // driver tasks (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic drive_phase(input logic v, input int n);
        i_sig_in = v;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // the rise that opens this period closes the pending one
    task automatic push_pending();
        if (pend_ok) exp_q.push_back({pend_h[15:0], pend_l[15:0]});
        pend_ok = 1'b0;
    endtask

    task automatic drive_period(input int h, input int l);
        push_pending();
        drive_phase(1'b1, h);
        drive_phase(1'b0, l);
        pend_h  = h;
        pend_l  = l;
        pend_ok = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_hi"},    32'(o_high_cnt),   0);
        check({tag, "_lo"},    32'(o_low_cnt),    0);
        check({tag, "_per"},   32'(o_period_cnt), 0);
        check({tag, "_valid"}, 32'(o_valid),      0);
        check({tag, "_busy"},  32'(o_busy),       0);
        check({tag, "_stuck"}, 32'(o_stuck),      0);
        check({tag, "_state"}, 32'(o_state),      32'(ST_IDLE));
    endtask

    // ------------------------------------------------------------------
    // monitor
    // ------------------------------------------------------------------
    initial begin
        logic        prev_valid;
        logic [31:0] e;
        int          eh;
        int          el;
        prev_valid = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_valid === 1'b1) begin
                check("valid_width", 32'(prev_valid), 0);
                if (async_mode) begin
                    async_n++;
                    check("async_hi",  32'(o_high_cnt >= 6 && o_high_cnt <= 7), 1);
                    check("async_lo",  32'(o_low_cnt >= 6 && o_low_cnt <= 7), 1);
                    check("async_per", 32'(o_period_cnt >= 13 && o_period_cnt <= 14), 1);
                end else if (exp_q.size() == 0) begin
                    check("valid_unexpected", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    eh = int'(e[31:16]);
                    el = int'(e[15:0]);
                    check("sb_hi",  32'(o_high_cnt),   32'(eh));
                    check("sb_lo",  32'(o_low_cnt),    32'(el));
                    check("sb_per", 32'(o_period_cnt), 32'(eh + el));
                end
            end
            prev_valid = o_valid;
        end
    end

    // ------------------------------------------------------------------
    // main sequence
    // ------------------------------------------------------------------
    initial begin
        int h;
        int l;
        int wait_cyc;

        i_rst    = 1'b1;
        i_enable = 1'b1;
        i_sig_in = 1'b0;
        @(posedge i_clk);
        #1;

        // reset while enabled and toggling
        for (int i = 0; i < 6; i++) drive_phase((i % 2) == 0, 1);
        check_zero_outputs("rst");
        i_rst = 1'b0;
        for (int i = 0; i < SYNC + 2; i++) begin
            drive_phase(1'b0, 1);
            check("rst_novalid", 32'(o_valid), 0);
        end
        check("wait_state", 32'(o_state), 32'(ST_WAIT_RISE));
        check("wait_busy",  32'(o_busy),  1);

        // 50 % duty, 10-cycle period
        for (int i = 0; i < 6; i++) drive_period(5, 5);

        // 30 % then 70 % duty, 50-cycle period
        for (int i = 0; i < 4; i++) drive_period(15, 35);
        for (int i = 0; i < 4; i++) drive_period(35, 15);

        // random phases including the 1-cycle minimum
        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(1, 30);
            l = $urandom_range(1, 30);
            drive_period(h, l);
        end
        for (int i = 0; i < 3; i++) drive_period(1, 1);

        // rise arrives on the same cycle the low count reaches TIMEOUT
        drive_period(5, TIMEOUT);
        drive_period(5, 5);
        check("edge_beats_to_stuck", 32'(o_stuck), 0);

        // stall in MEAS_LOW after a valid measurement
        drive_period(5, 5);
        push_pending();
        drive_phase(1'b1, 5);
        drive_phase(1'b0, TIMEOUT + SYNC);
        check("stall_pre_stuck", 32'(o_stuck), 0);
        drive_phase(1'b0, 1);
        check("stall_stuck",  32'(o_stuck),      1);
        check("stall_hi",     32'(o_high_cnt),   5);
        check("stall_lo",     32'(o_low_cnt),    5);
        check("stall_per",    32'(o_period_cnt), 10);
        check("stall_state",  32'(o_state),      32'(ST_WAIT_RISE));

        // resume at 50 %: stuck clears only with the next valid
        drive_period(5, 5);
        check("resume_still_stuck", 32'(o_stuck), 1);
        for (int i = 0; i < 3; i++) drive_period(5, 5);
        check("resume_stuck_clr", 32'(o_stuck), 0);

        // enable dropped mid-MEAS_HIGH for 3 cycles
        for (int i = 0; i < 2; i++) drive_period(7, 3);
        push_pending();
        drive_phase(1'b1, 4);
        check("en_meas_high", 32'(o_state), 32'(ST_MEAS_HIGH));
        i_enable = 1'b0;
        drive_phase(1'b1, 3);
        check("en_idle_state", 32'(o_state),    32'(ST_IDLE));
        check("en_idle_busy",  32'(o_busy),     0);
        check("en_hold_hi",    32'(o_high_cnt), 7);
        check("en_hold_lo",    32'(o_low_cnt),  3);
        i_enable = 1'b1;
        drive_phase(1'b1, 3);
        drive_phase(1'b0, 5);
        check("en_hold2_hi",   32'(o_high_cnt), 7);
        check("en_hold2_lo",   32'(o_low_cnt),  3);
        for (int i = 0; i < 3; i++) drive_period(4, 6);

        // reset in the middle of a measurement
        push_pending();
        drive_phase(1'b1, 4);
        i_rst = 1'b1;
        drive_phase(1'b1, 1);
        check_zero_outputs("midrst");
        i_rst = 1'b0;
        for (int i = 0; i < SYNC + 2; i++) begin
            drive_phase(1'b0, 1);
            check("midrst_novalid", 32'(o_valid), 0);
        end

        // every pushed result must have been produced
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 200) begin
            drive_phase(1'b0, 1);
            wait_cyc++;
        end
        check("sb_drained", 32'(exp_q.size()), 0);

        // asynchronous 7.3 MHz input (13.7 clk cycles per period)
        async_mode = 1'b1;
        #($urandom_range(1, 99));
        for (int i = 0; i < 20; i++) begin
            i_sig_in = 1'b1;
            #685;
            i_sig_in = 1'b0;
            #685;
        end
        repeat (5) @(posedge i_clk);
        #1;
        check("async_count", 32'(async_n), 19);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
